// File: rtl/i2s_tx_scheduler_if.sv
// Sample-feed bundle between the two upstream sources, the scheduler and the I2S transmitter.
interface i2s_tx_scheduler_if #(
  parameter int unsigned UCNT_W = 16
) ();
  localparam int unsigned DATA_W = 16;

  logic [DATA_W-1:0] src0_data;
  logic              src0_valid;
  logic              src0_ready;
  logic [DATA_W-1:0] src1_data;
  logic              src1_valid;
  logic              src1_ready;
  logic [DATA_W-1:0] tx_data;
  logic              sample_stb;
  logic              grant_id;
  logic              underrun;
  logic [UCNT_W-1:0] underrun_cnt;

  modport master (
    input  src0_data, src0_valid, src1_data, src1_valid,
    output src0_ready, src1_ready, tx_data, sample_stb, grant_id, underrun, underrun_cnt
  );

  modport slave (
    output src0_data, src0_valid, src1_data, src1_valid,
    input  src0_ready, src1_ready, tx_data, sample_stb, grant_id, underrun, underrun_cnt
  );
endinterface

// File: rtl/i2s_tx_scheduler.sv
// Fetches one mono sample per lrclk period from src0/src1 after each lrclk rise and
// commits it to tx_data ahead of the transmitter's load at the following lrclk fall.
module i2s_tx_scheduler #(
  parameter int unsigned FETCH_WINDOW  = 64,
  parameter bit          UNDERRUN_ZERO = 1'b1,
  parameter int unsigned UCNT_W        = 16
) (
  input  logic                   clk_i2s,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic                   tx_lrclk,
  i2s_tx_scheduler_if.master     bus
);
  localparam int unsigned WCNT_W = 7;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              lrclk_q;
  logic [1:0]        mode_q;
  logic [WCNT_W-1:0] wcnt;

  logic rise_c;
  logic in_wait_c;
  logic pref_sel_c;
  logic alt_ok_c;
  logic pref_valid_c;
  logic alt_valid_c;
  logic pick_c;
  logic pick_sel_c;
  logic timeout_c;

  // State register
  always_ff @(posedge clk_i2s) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; disable forces IDLE from anywhere
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise_c) state_nxt = WAIT;
        WAIT:    if (pick_c || timeout_c) state_nxt = COMMIT;
        COMMIT:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Arbitration and combinational pop strobes
  always_comb begin
    rise_c     = tx_lrclk & ~lrclk_q;
    in_wait_c  = (state == WAIT) & enable & ~reset;
    pref_sel_c = 1'b0;
    case (mode_q)
      2'b01:   pref_sel_c = 1'b1;
      2'b11:   pref_sel_c = ~bus.grant_id;
      default: pref_sel_c = 1'b0;
    endcase
    alt_ok_c       = mode_q[1];
    pref_valid_c   = pref_sel_c ? bus.src1_valid : bus.src0_valid;
    alt_valid_c    = pref_sel_c ? bus.src0_valid : bus.src1_valid;
    pick_c         = in_wait_c & (pref_valid_c | (alt_ok_c & alt_valid_c));
    pick_sel_c     = pref_valid_c ? pref_sel_c : ~pref_sel_c;
    timeout_c      = in_wait_c & ~pick_c & (wcnt == WCNT_W'(FETCH_WINDOW - 1));
    bus.src0_ready = pick_c & ~pick_sel_c;
    bus.src1_ready = pick_c & pick_sel_c;
  end

  // Registered datapath: edge history, window counter, committed sample and status
  always_ff @(posedge clk_i2s) begin
    if (reset) begin
      lrclk_q          <= 1'b1;
      mode_q           <= 2'b00;
      wcnt             <= '0;
      bus.tx_data      <= '0;
      bus.sample_stb   <= 1'b0;
      bus.grant_id     <= 1'b0;
      bus.underrun     <= 1'b0;
      bus.underrun_cnt <= '0;
    end else begin
      lrclk_q        <= tx_lrclk;
      bus.sample_stb <= 1'b0;
      bus.underrun   <= 1'b0;
      if (!enable) begin
        bus.tx_data <= '0;
      end else if ((state == IDLE) && rise_c) begin
        mode_q <= mode;
        wcnt   <= '0;
      end else if (pick_c) begin
        bus.tx_data    <= pick_sel_c ? bus.src1_data : bus.src0_data;
        bus.grant_id   <= pick_sel_c;
        bus.sample_stb <= 1'b1;
      end else if (timeout_c) begin
        bus.underrun   <= 1'b1;
        bus.sample_stb <= 1'b1;
        if (bus.underrun_cnt != {UCNT_W{1'b1}}) bus.underrun_cnt <= bus.underrun_cnt + UCNT_W'(1);
        if (UNDERRUN_ZERO) bus.tx_data <= '0;
      end else if (state == WAIT) begin
        wcnt <= wcnt + WCNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Frame-level checks of i2s_tx_scheduler: two instances (zeroing/16-bit counter and
// holding/2-bit counter) share stimulus; expectations come from arrival-time arithmetic.
module tb_i2s_tx_scheduler;
  localparam int HALF = 100;
  localparam int NONE = 127;

  logic        clk_i2s = 1'b0;
  logic        reset;
  logic        enable;
  logic        tx_lrclk;
  logic [1:0]  mode;
  logic [15:0] s0d, s1d;
  logic        s0v, s1v;

  int total = 0;
  int bad   = 0;

  logic        exp_g;
  logic [15:0] exp_tx_a, exp_tx_b;
  int          exp_cnt_a, exp_cnt_b;

  always #5 clk_i2s = ~clk_i2s;

  i2s_tx_scheduler_if #(.UCNT_W(16)) ifa ();
  i2s_tx_scheduler_if #(.UCNT_W(2))  ifb ();

  assign ifa.src0_data  = s0d;
  assign ifa.src0_valid = s0v;
  assign ifa.src1_data  = s1d;
  assign ifa.src1_valid = s1v;
  assign ifb.src0_data  = s0d;
  assign ifb.src0_valid = s0v;
  assign ifb.src1_data  = s1d;
  assign ifb.src1_valid = s1v;

  i2s_tx_scheduler #(.FETCH_WINDOW(64), .UNDERRUN_ZERO(1'b1), .UCNT_W(16)) dut_a (
    .clk_i2s(clk_i2s), .reset(reset), .enable(enable), .mode(mode), .tx_lrclk(tx_lrclk),
    .bus(ifa.master)
  );

  i2s_tx_scheduler #(.FETCH_WINDOW(64), .UNDERRUN_ZERO(1'b0), .UCNT_W(2)) dut_b (
    .clk_i2s(clk_i2s), .reset(reset), .enable(enable), .mode(mode), .tx_lrclk(tx_lrclk),
    .bus(ifb.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One lrclk period: high phase (fetch + commit), then low phase (must stay quiet).
  // abort_kind: 0 none, 1 enable drop, 2 reset, applied at WAIT offset abort_at.
  task automatic run_frame(input int fr, input logic [1:0] m, input int a0, input int a1,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input int abort_kind, input int abort_at);
    logic pref, psrc, pop, und;
    int   tp, ta, t, j, evt_j, exp_evt;
    int   r0, r1, stb_a, stb_b, und_a, und_b, viol, unst, quiet;
    bit   pd0, pd1, seen_a, seen_b;

    pref = (m == 2'b01) ? 1'b1 : ((m == 2'b11) ? ~exp_g : 1'b0);
    tp   = pref ? a1 : a0;
    ta   = m[1] ? (pref ? a0 : a1) : NONE;
    t    = (tp <= ta) ? tp : ta;
    psrc = (tp <= ta) ? pref : ~pref;
    pop  = (abort_kind == 0) && (t < 64);
    und  = (abort_kind == 0) && !pop;
    exp_evt = pop ? t : (und ? 64 : -1);
    if (abort_kind == 2) begin
      exp_g = 1'b0; exp_tx_a = '0; exp_tx_b = '0; exp_cnt_a = 0; exp_cnt_b = 0;
    end else if (abort_kind == 1) begin
      exp_tx_a = '0; exp_tx_b = '0;
    end else if (pop) begin
      exp_g = psrc; exp_tx_a = psrc ? d1 : d0; exp_tx_b = exp_tx_a;
    end else begin
      exp_tx_a  = '0;
      exp_cnt_a = (exp_cnt_a == 65535) ? 65535 : exp_cnt_a + 1;
      exp_cnt_b = (exp_cnt_b == 3) ? 3 : exp_cnt_b + 1;
    end

    r0 = 0; r1 = 0; stb_a = 0; stb_b = 0; und_a = 0; und_b = 0; viol = 0; unst = 0; quiet = 0;
    pd0 = 0; pd1 = 0; seen_a = 0; seen_b = 0; evt_j = -1;
    s0d = d0; s1d = d1;
    for (int k = 0; k < HALF; k++) begin
      j = k - 1;
      tx_lrclk = 1'b1;
      mode   = (k == 0) ? m : 2'($urandom);
      enable = 1'b1;
      reset  = 1'b0;
      s0v = (j >= a0) && !pd0;
      s1v = (j >= a1) && !pd1;
      if (abort_kind != 0 && j == abort_at) begin
        s0v = 1'b1; s1v = 1'b1;
        if (abort_kind == 1) enable = 1'b0;
        else                 reset  = 1'b1;
      end
      @(negedge clk_i2s);
      if (ifa.src0_ready) begin r0++; pd0 = 1; evt_j = j; if (!s0v) viol++; end
      if (ifa.src1_ready) begin r1++; pd1 = 1; evt_j = j; if (!s1v) viol++; end
      if (ifa.src0_ready && ifa.src1_ready) viol++;
      if (ifa.src0_ready !== ifb.src0_ready || ifa.src1_ready !== ifb.src1_ready) viol++;
      if (ifa.underrun) begin und_a++; evt_j = j; end
      if (ifb.underrun) und_b++;
      if (ifa.sample_stb) begin stb_a++; seen_a = 1; end
      if (ifb.sample_stb) begin stb_b++; seen_b = 1; end
      if (seen_a && ifa.tx_data !== exp_tx_a) unst++;
      if (seen_b && ifb.tx_data !== exp_tx_b) unst++;
      if (abort_kind != 0 && j == abort_at + 1) begin
        chk($sformatf("f%0d abort_tx_a", fr), 32'(ifa.tx_data), 32'(exp_tx_a));
        chk($sformatf("f%0d abort_tx_b", fr), 32'(ifb.tx_data), 32'(exp_tx_b));
        chk($sformatf("f%0d abort_cnt_a", fr), 32'(ifa.underrun_cnt), 32'(exp_cnt_a));
      end
      @(posedge clk_i2s); #1;
    end

    chk($sformatf("f%0d pop0", fr), 32'(r0), 32'(pop && !psrc));
    chk($sformatf("f%0d pop1", fr), 32'(r1), 32'(pop && psrc));
    chk($sformatf("f%0d evt_at", fr), 32'(evt_j), 32'(exp_evt));
    chk($sformatf("f%0d stb_a", fr), 32'(stb_a), 32'(abort_kind == 0));
    chk($sformatf("f%0d stb_b", fr), 32'(stb_b), 32'(abort_kind == 0));
    chk($sformatf("f%0d und_a", fr), 32'(und_a), 32'(und));
    chk($sformatf("f%0d und_b", fr), 32'(und_b), 32'(und));
    chk($sformatf("f%0d tx_a", fr), 32'(ifa.tx_data), 32'(exp_tx_a));
    chk($sformatf("f%0d tx_b", fr), 32'(ifb.tx_data), 32'(exp_tx_b));
    chk($sformatf("f%0d grant_a", fr), 32'(ifa.grant_id), 32'(exp_g));
    chk($sformatf("f%0d grant_b", fr), 32'(ifb.grant_id), 32'(exp_g));
    chk($sformatf("f%0d cnt_a", fr), 32'(ifa.underrun_cnt), 32'(exp_cnt_a));
    chk($sformatf("f%0d cnt_b", fr), 32'(ifb.underrun_cnt), 32'(exp_cnt_b));
    chk($sformatf("f%0d stable", fr), 32'(unst), 32'(0));
    chk($sformatf("f%0d proto", fr), 32'(viol), 32'(0));

    tx_lrclk = 1'b0; s0v = 1'b0; s1v = 1'b0; mode = m;
    for (int k = 0; k < HALF; k++) begin
      @(negedge clk_i2s);
      if (ifa.src0_ready || ifa.src1_ready || ifa.sample_stb || ifa.underrun ||
          ifb.src0_ready || ifb.src1_ready || ifb.sample_stb || ifb.underrun) quiet++;
      @(posedge clk_i2s); #1;
    end
    chk($sformatf("f%0d quiet_low", fr), 32'(quiet), 32'(0));
  endtask

  initial begin
    int fr;
    int ra0, ra1;
    reset = 1'b1; enable = 1'b0; tx_lrclk = 1'b0; mode = 2'b00;
    s0v = 1'b0; s1v = 1'b0; s0d = '0; s1d = '0;
    exp_g = 1'b0; exp_tx_a = '0; exp_tx_b = '0; exp_cnt_a = 0; exp_cnt_b = 0;
    repeat (3) @(posedge clk_i2s);
    @(negedge clk_i2s);
    chk("rst tx_a",    32'(ifa.tx_data),      32'(0));
    chk("rst tx_b",    32'(ifb.tx_data),      32'(0));
    chk("rst grant_a", 32'(ifa.grant_id),     32'(0));
    chk("rst cnt_a",   32'(ifa.underrun_cnt), 32'(0));
    chk("rst cnt_b",   32'(ifb.underrun_cnt), 32'(0));
    chk("rst stb",     32'({ifa.sample_stb, ifb.sample_stb}), 32'(0));
    chk("rst und",     32'({ifa.underrun, ifb.underrun}),     32'(0));
    chk("rst ready",   32'({ifa.src0_ready, ifa.src1_ready, ifb.src0_ready, ifb.src1_ready}), 32'(0));
    @(posedge clk_i2s); #1;
    reset = 1'b0; enable = 1'b1;
    repeat (5) begin @(posedge clk_i2s); #1; end

    fr = 0;
    repeat (3) begin run_frame(fr, 2'b00, 0, NONE, 16'h1234, 16'h5555, 0, 0); fr++; end
    repeat (4) begin run_frame(fr, 2'b11, 0, 0, 16'hA000 + 16'(fr), 16'hB000 + 16'(fr), 0, 0); fr++; end
    run_frame(fr, 2'b10, NONE, 5, 16'h1111, 16'hBEEF, 0, 0); fr++;
    run_frame(fr, 2'b10, NONE, NONE, 16'h2222, 16'h3333, 0, 0); fr++;
    run_frame(fr, 2'b00, 63, NONE, 16'h6363, 16'h0000, 0, 0); fr++;
    run_frame(fr, 2'b01, 0, NONE, 16'h7777, 16'h8888, 0, 0); fr++;
    repeat (2) begin run_frame(fr, 2'b11, NONE, NONE, 16'h4444, 16'h9999, 0, 0); fr++; end
    run_frame(fr, 2'b10, 3, 3, 16'hC0DE, 16'hFACE, 0, 0); fr++;
    run_frame(fr, 2'b00, NONE, NONE, 16'h0F0F, 16'hF0F0, 1, 10); fr++;
    run_frame(fr, 2'b10, 2, 9, 16'h5A5A, 16'hA5A5, 0, 0); fr++;
    run_frame(fr, 2'b11, NONE, NONE, 16'h1357, 16'h2468, 2, 20); fr++;
    run_frame(fr, 2'b11, 0, 0, 16'hD00D, 16'hE00E, 0, 0); fr++;

    repeat (28) begin
      ra0 = ($urandom_range(0, 3) == 0) ? NONE : int'($urandom_range(0, 75));
      ra1 = ($urandom_range(0, 3) == 0) ? NONE : int'($urandom_range(0, 75));
      run_frame(fr, 2'($urandom), ra0, ra1, 16'($urandom), 16'($urandom), 0, 0);
      fr++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
